key_scan: RTL and testbench

KEY_SCAN -- requirements
Module: key_scan

---
 rtl/keypad_pkg.sv | 14 +
 rtl/tick_gen.sv | 15 +
 rtl/key_scan.sv | 82 ++++++++
 tb/tb_key_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner FSM state encoding and column drive helpers
package keypad_pkg;
  localparam logic [1:0] SCAN = 2'd0;
  localparam logic [1:0] DEB  = 2'd1;
  localparam logic [1:0] HELD = 2'd2;
  localparam logic [1:0] REL  = 2'd3;
  localparam logic [3:0] COL_FIRST = 4'b1110;
  function automatic logic [3:0] col_rot(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = cnt == 16'(DIV - 1);
  // count 0..DIV-1 and wrap on the tick cycle
  always_ff @(posedge clk)
    if (rst || tick) cnt <= '0;
    else cnt <= cnt + 16'd1;
endmodule

// File: rtl/key_scan.sv
// key_scan: 4x4 keypad column scanner with press/release debounce
module key_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam logic [3:0] FR = 4'(DEB_FRAMES);
  logic       tick;
  logic [3:0] s1, rs, cand, deb_cnt, rel_cnt, cand_n;
  logic [1:0] state;
  logic       hit;
  tick_gen #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign cand_n   = {low_idx(col), low_idx(rs)};
  assign hit      = !rs[cand[1:0]];
  assign key_held = state == HELD || state == REL;
  // synchronize rows and step the scan/debounce FSM on each tick
  always_ff @(posedge clk)
    if (rst) begin
      s1        <= 4'hF;
      rs        <= 4'hF;
      state     <= SCAN;
      col       <= COL_FIRST;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
    end else begin
      s1        <= row_in;
      rs        <= s1;
      key_valid <= 1'b0;
      if (tick)
        case (state)
          SCAN:
            if (rs == 4'hF) col <= col_rot(col);
            else begin
              cand    <= cand_n;
              deb_cnt <= 4'd1;
              if (FR == 4'd1) begin
                state     <= HELD;
                key_code  <= cand_n;
                key_valid <= 1'b1;
              end else state <= DEB;
            end
          DEB:
            if (hit) begin
              deb_cnt <= deb_cnt + 4'd1;
              if (deb_cnt + 4'd1 == FR) begin
                state     <= HELD;
                key_code  <= cand;
                key_valid <= 1'b1;
              end
            end else begin
              state <= SCAN;
              col   <= col_rot(col);
            end
          HELD:
            if (!hit) begin
              rel_cnt <= 4'd1;
              state   <= FR == 4'd1 ? SCAN : REL;
              col     <= FR == 4'd1 ? col_rot(col) : col;
            end
          REL:
            if (!hit) begin
              rel_cnt <= rel_cnt + 4'd1;
              if (rel_cnt + 4'd1 == FR) begin
                state <= SCAN;
                col   <= col_rot(col);
              end
            end else state <= HELD;
        endcase
    end
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: directed checks of keypad scanning, debounce and reset
module tb_key_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed;
  int          passed = 0, total = 0, vcnt = 0, v0, n;
  logic [3:0]  c, prev;
  key_scan #(.SCAN_DIV(4), .DEB_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );
  always #5 clk = ~clk;
  // keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    for (int k = 0; k < 16; k++)
      if (pressed[k] && !col[k / 4]) row_in[k % 4] = 1'b0;
  end
  // count key_valid pulses
  always @(negedge clk) vcnt <= vcnt + (key_valid ? 1 : 0);
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  initial begin
    rst = 1'b1;
    pressed = '0;
    repeat (3) @(negedge clk);
    chk("rst_col", int'(col), 4'b1110);
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    rst = 1'b0;
    v0 = vcnt;
    c = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      prev = col;
      n = 0;
      do begin @(negedge clk); n++; end while (col == prev && n < 10);
      c = {c[2:0], c[3]};
      chk("idle_col", int'(col), int'(c));
      chk("idle_gap", n, 4);
    end
    chk("idle_novalid", vcnt - v0, 0);
    v0 = vcnt;
    pressed[9] = 1'b1;
    n = 0;
    while (!key_valid && n < 40) begin @(negedge clk); n++; end
    chk("press_seen", int'(key_valid), 1);
    chk("press_latency_ok", int'(n <= 30), 1);
    chk("press_code", int'(key_code), 9);
    chk("press_held", int'(key_held), 1);
    repeat (20) @(negedge clk);
    chk("press_col_frozen", int'(col), 4'b1011);
    chk("press_held_late", int'(key_held), 1);
    pressed = '0;
    repeat (9) @(negedge clk);
    chk("rel_held_2ticks", int'(key_held), 1);
    repeat (4) @(negedge clk);
    chk("rel_held_3ticks", int'(key_held), 0);
    chk("press_once", vcnt - v0, 1);
    v0 = vcnt;
    pressed[9] = 1'b1;
    n = 0;
    while (col == 4'b1011 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (col != 4'b1011 && n < 40) begin @(negedge clk); n++; end
    chk("bnc_reach_col2", int'(col), 4'b1011);
    repeat (8) @(negedge clk);
    pressed = '0;
    n = 0;
    while (col == 4'b1011 && n < 20) begin @(negedge clk); n++; end
    chk("bnc_resume_col3", int'(col), 4'b0111);
    chk("bnc_held", int'(key_held), 0);
    chk("bnc_novalid", vcnt - v0, 0);
    v0 = vcnt;
    pressed[4] = 1'b1;
    pressed[7] = 1'b1;
    n = 0;
    while (!key_valid && n < 60) begin @(negedge clk); n++; end
    chk("multi_seen", int'(key_valid), 1);
    chk("multi_code", int'(key_code), 4);
    pressed[12] = 1'b1;
    repeat (40) @(negedge clk);
    chk("multi_col_frozen", int'(col), 4'b1101);
    chk("multi_held", int'(key_held), 1);
    chk("multi_code_kept", int'(key_code), 4);
    chk("multi_once", vcnt - v0, 1);
    pressed = '0;
    n = 0;
    while (key_held && n < 40) begin @(negedge clk); n++; end
    chk("multi_release", int'(key_held), 0);
    repeat (2) @(negedge clk);
    chk("multi_once_after", vcnt - v0, 1);
    v0 = vcnt;
    pressed[9] = 1'b1;
    n = 0;
    while (!key_valid && n < 60) begin @(negedge clk); n++; end
    chk("glitch_seen", int'(key_valid), 1);
    chk("glitch_code", int'(key_code), 9);
    pressed[9] = 1'b0;
    repeat (4) @(negedge clk);
    pressed[9] = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_held", int'(key_held), 1);
    chk("glitch_once", vcnt - v0, 1);
    pressed = '0;
    n = 0;
    while (key_held && n < 40) begin @(negedge clk); n++; end
    chk("glitch_release", int'(key_held), 0);
    repeat (2) @(negedge clk);
    chk("glitch_once_after", vcnt - v0, 1);
    v0 = vcnt;
    pressed[9] = 1'b1;
    n = 0;
    while (col == 4'b1011 && n < 40) begin @(negedge clk); n++; end
    n = 0;
    while (col != 4'b1011 && n < 40) begin @(negedge clk); n++; end
    chk("rstdeb_reach_col2", int'(col), 4'b1011);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    pressed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rstdeb_col", int'(col), 4'b1110);
    chk("rstdeb_held", int'(key_held), 0);
    chk("rstdeb_code", int'(key_code), 0);
    repeat (40) @(negedge clk);
    chk("rstdeb_novalid", vcnt - v0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
